// File: rtl/rs_glb_pkg.sv
// rtl/rs_glb_pkg.sv - shared constants, streamer state type and write-select encodings for the global buffer
package rs_glb_pkg;
  localparam int GLB_DW         = 8;
  localparam int GLB_FMAP_BANKS = 7;
  localparam int GLB_FMAP_DEPTH = 32;
  localparam int GLB_WT_BANKS   = 5;
  localparam int GLB_WT_DEPTH   = 64;
  localparam int GLB_BK_W       = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } glb_state_t;

  localparam logic SEL_FMAP = 1'b0;
  localparam logic SEL_WT   = 1'b1;
endpackage

// File: rtl/rs_glb_streamer.sv
// rtl/rs_glb_streamer.sv - one memory class: banked storage, write decode and burst read streamer
module rs_glb_streamer
  import rs_glb_pkg::*;
#(
  parameter int NBANK = GLB_FMAP_BANKS,
  parameter int DEPTH = GLB_FMAP_DEPTH,
  parameter int DW    = GLB_DW,
  parameter int BK_W  = GLB_BK_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [BK_W-1:0]     wr_bank,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DW-1:0]       wr_data,
  input  logic                start,
  input  logic [AW-1:0]       base,
  input  logic [AW:0]         len,
  output logic                busy,
  output logic                valid,
  input  logic                ready,
  output logic                last,
  output logic [NBANK*DW-1:0] data
);
  localparam int MW = $clog2(NBANK * DEPTH);

  // Banks are stored bank-major in one array.
  logic [DW-1:0] mem [NBANK*DEPTH];

  logic          wr_ok;
  logic [MW-1:0] wr_idx;
  assign wr_ok  = wr_en && (int'(wr_bank) < NBANK);
  assign wr_idx = MW'(wr_bank) * MW'(DEPTH) + MW'(wr_addr);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_idx] <= wr_data;
  end

  glb_state_t  state;
  logic [AW-1:0] ptr;
  logic [AW:0]   rem;
  logic          fetch;

  assign fetch = (state == RUN) && (rem != '0) && (!valid || ready);

  // The output register samples memory with non-blocking reads, so a same-edge write is seen as old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      rem   <= '0;
      busy  <= 1'b0;
      valid <= 1'b0;
      last  <= 1'b0;
      data  <= '0;
    end else if (state == IDLE) begin
      if (start && (len != '0)) begin
        ptr   <= base;
        rem   <= len;
        busy  <= 1'b1;
        state <= RUN;
      end
    end else begin
      if (valid && ready && last) begin
        state <= IDLE;
        busy  <= 1'b0;
        valid <= 1'b0;
        last  <= 1'b0;
      end else if (fetch) begin
        for (int k = 0; k < NBANK; k++) begin
          data[k*DW +: DW] <= mem[MW'(k * DEPTH) + MW'(ptr)];
        end
        valid <= 1'b1;
        last  <= (rem == (AW+1)'(1));
        ptr   <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        rem   <= rem - 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/rs_glb_stream.sv
// rtl/rs_glb_stream.sv - row-stationary global buffer: fmap and weight banks with a shared write port
module rs_glb_stream
  import rs_glb_pkg::*;
#(
  parameter int DW         = GLB_DW,
  parameter int FMAP_BANKS = GLB_FMAP_BANKS,
  parameter int FMAP_DEPTH = GLB_FMAP_DEPTH,
  parameter int WT_BANKS   = GLB_WT_BANKS,
  parameter int WT_DEPTH   = GLB_WT_DEPTH,
  parameter int FA_W       = $clog2(FMAP_DEPTH),
  parameter int WA_W       = $clog2(WT_DEPTH),
  parameter int BK_W       = GLB_BK_W,
  parameter int A_W        = (FA_W > WA_W) ? FA_W : WA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic                     wr_sel,
  input  logic [BK_W-1:0]          wr_bank,
  input  logic [A_W-1:0]           wr_addr,
  input  logic [DW-1:0]            wr_data,
  input  logic                     f_start,
  input  logic [FA_W-1:0]          f_base,
  input  logic [FA_W:0]            f_len,
  output logic                     f_busy,
  output logic                     f_valid,
  input  logic                     f_ready,
  output logic                     f_last,
  output logic [FMAP_BANKS*DW-1:0] f_data,
  input  logic                     w_start,
  input  logic [WA_W-1:0]          w_base,
  input  logic [WA_W:0]            w_len,
  output logic                     w_busy,
  output logic                     w_valid,
  input  logic                     w_ready,
  output logic                     w_last,
  output logic [WT_BANKS*DW-1:0]   w_data
);
  logic f_wr_en, w_wr_en;
  assign f_wr_en = wr_en && (wr_sel == SEL_FMAP);
  assign w_wr_en = wr_en && (wr_sel == SEL_WT);

  rs_glb_streamer #(
    .NBANK(FMAP_BANKS), .DEPTH(FMAP_DEPTH), .DW(DW), .BK_W(BK_W), .AW(FA_W)
  ) u_fmap (
    .clk(clk), .rst_n(rst_n),
    .wr_en(f_wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr[FA_W-1:0]), .wr_data(wr_data),
    .start(f_start), .base(f_base), .len(f_len),
    .busy(f_busy), .valid(f_valid), .ready(f_ready), .last(f_last), .data(f_data)
  );

  rs_glb_streamer #(
    .NBANK(WT_BANKS), .DEPTH(WT_DEPTH), .DW(DW), .BK_W(BK_W), .AW(WA_W)
  ) u_wt (
    .clk(clk), .rst_n(rst_n),
    .wr_en(w_wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr[WA_W-1:0]), .wr_data(wr_data),
    .start(w_start), .base(w_base), .len(w_len),
    .busy(w_busy), .valid(w_valid), .ready(w_ready), .last(w_last), .data(w_data)
  );
endmodule

// File: tb/tb_rs_glb_stream.sv
// tb/tb_rs_glb_stream.sv - scoreboard bench for rs_glb_stream with a word-level memory model
module tb_rs_glb_stream;
  localparam int FB = 7, FD = 32, WB = 5, WD = 64, FA = 5, WA = 6, BK = 3;

  logic clk, rst_n;
  logic wr_en, wr_sel;
  logic [BK-1:0] wr_bank;
  logic [WA-1:0] wr_addr;
  logic [7:0] wr_data;
  logic f_start, f_busy, f_valid, f_ready, f_last;
  logic [FA-1:0] f_base;
  logic [FA:0] f_len;
  logic [FB*8-1:0] f_data;
  logic w_start, w_busy, w_valid, w_ready, w_last;
  logic [WA-1:0] w_base;
  logic [WA:0] w_len;
  logic [WB*8-1:0] w_data;

  rs_glb_stream dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .f_start(f_start), .f_base(f_base), .f_len(f_len), .f_busy(f_busy), .f_valid(f_valid),
    .f_ready(f_ready), .f_last(f_last), .f_data(f_data),
    .w_start(w_start), .w_base(w_base), .w_len(w_len), .w_busy(w_busy), .w_valid(w_valid),
    .w_ready(w_ready), .w_last(w_last), .w_data(w_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [7:0] fm [FB][FD];
  logic [7:0] wm [WB][WD];
  typedef struct { logic [63:0] d; logic l; } exp_t;
  exp_t fq[$], wq[$];

  function automatic logic [63:0] f_word(int a);
    logic [63:0] v = '0;
    for (int k = 0; k < FB; k++) v[k*8 +: 8] = fm[k][a % FD];
    return v;
  endfunction

  function automatic logic [63:0] w_word(int a);
    logic [63:0] v = '0;
    for (int k = 0; k < WB; k++) v[k*8 +: 8] = wm[k][a % WD];
    return v;
  endfunction

  task automatic push_f(int base, int len);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      e.d = f_word(base + i); e.l = (i == len - 1); fq.push_back(e);
    end
  endtask

  task automatic push_w(int base, int len);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      e.d = w_word(base + i); e.l = (i == len - 1); wq.push_back(e);
    end
  endtask

  // Ready policy: 0 = always ready, 1 = random, 2 = scripted pattern consumed on valid cycles.
  int f_mode = 0, w_mode = 0, f_acc = 0, w_acc = 0;
  bit fpat[$];

  initial begin
    exp_t e;
    logic f_held, w_held, f_hl, w_hl, f_lacc, w_lacc;
    logic [63:0] f_hd, w_hd;
    f_held = 0; w_held = 0; f_lacc = 0; w_lacc = 0; f_hl = 0; w_hl = 0; f_hd = '0; w_hd = '0;
    f_ready = 1'b1; w_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        f_held = 0; w_held = 0; f_lacc = 0; w_lacc = 0;
        f_ready = 1'b1; w_ready = 1'b1;
      end else begin
        if (f_held) begin
          chk("f_hold_data", 64'(f_data), f_hd);
          chk("f_hold_valid_last", 64'({f_valid, f_last}), 64'({1'b1, f_hl}));
        end
        if (f_lacc) chk("f_end_state", 64'({f_busy, f_valid, f_last}), 64'(0));
        if (f_mode == 2 && f_valid && fpat.size() > 0) f_ready = fpat.pop_front();
        else if (f_mode == 1) f_ready = ($urandom_range(0, 3) != 0);
        else f_ready = 1'b1;
        f_held = 0; f_lacc = 0;
        if (f_valid && f_ready) begin
          if (fq.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL f_unexpected_word: got %h expected none", f_data);
          end else begin
            e = fq.pop_front();
            chk("f_data", 64'(f_data), e.d);
            chk("f_last", 64'(f_last), 64'(e.l));
          end
          f_acc++; f_lacc = f_last;
        end else if (f_valid) begin
          f_held = 1; f_hd = 64'(f_data); f_hl = f_last;
        end

        if (w_held) begin
          chk("w_hold_data", 64'(w_data), w_hd);
          chk("w_hold_valid_last", 64'({w_valid, w_last}), 64'({1'b1, w_hl}));
        end
        if (w_lacc) chk("w_end_state", 64'({w_busy, w_valid, w_last}), 64'(0));
        if (w_mode == 1) w_ready = ($urandom_range(0, 3) != 0);
        else w_ready = 1'b1;
        w_held = 0; w_lacc = 0;
        if (w_valid && w_ready) begin
          if (wq.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL w_unexpected_word: got %h expected none", w_data);
          end else begin
            e = wq.pop_front();
            chk("w_data", 64'(w_data), e.d);
            chk("w_last", 64'(w_last), 64'(e.l));
          end
          w_acc++; w_lacc = w_last;
        end else if (w_valid) begin
          w_held = 1; w_hd = 64'(w_data); w_hl = w_last;
        end
      end
    end
  end

  task automatic wr(bit sel, int bank, int addr, logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = sel; wr_bank = BK'(bank); wr_addr = WA'(addr); wr_data = d;
    if (!sel && bank < FB) fm[bank][addr % FD] = d;
    else if (sel && bank < WB) wm[bank][addr % WD] = d;
  endtask

  task automatic wr_done();
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic start_bursts(bit df, int fb, int fl, bit dw, int wb, int wl);
    @(negedge clk);
    if (df) begin
      f_base = FA'(fb); f_len = (FA+1)'(fl); f_start = 1'b1;
      push_f(fb, fl);
    end
    if (dw) begin
      w_base = WA'(wb); w_len = (WA+1)'(wl); w_start = 1'b1;
      push_w(wb, wl);
    end
    @(negedge clk);
    f_start = 1'b0; w_start = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int t;
    for (t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (!f_busy && !w_busy) break;
    end
    chk({name, "_in_time"}, 64'(t < 3000), 64'(1));
    chk({name, "_queues_drained"}, 64'(fq.size() + wq.size()), 64'(0));
  endtask

  initial begin
    int a0, t;
    rst_n = 1'b0; wr_en = 0; wr_sel = 0; wr_bank = '0; wr_addr = '0; wr_data = '0;
    f_start = 0; f_base = '0; f_len = '0; w_start = 0; w_base = '0; w_len = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 64'({f_busy, f_valid, f_last, w_busy, w_valid, w_last}), 64'(0));
    chk("reset_f_data", 64'(f_data), 64'(0));
    chk("reset_w_data", 64'(w_data), 64'(0));
    rst_n = 1'b1;

    for (int b = 0; b < FB; b++) for (int a = 0; a < FD; a++) wr(0, b, a, 8'($urandom));
    for (int b = 0; b < WB; b++) for (int a = 0; a < WD; a++) wr(1, b, a, 8'($urandom));
    wr_done();

    // Single-word fmap burst with explicit latency checks.
    wr(0, 3, 5, 8'hA5); wr_done();
    @(negedge clk);
    f_base = 5; f_len = 1; f_start = 1'b1; push_f(5, 1);
    @(negedge clk);
    f_start = 1'b0;
    chk("t1_run_no_valid", 64'({f_busy, f_valid}), 64'(2'b10));
    @(negedge clk);
    chk("t1_first_valid", 64'({f_valid, f_last}), 64'(2'b11));
    chk("t1_bank3", 64'(f_data[31:24]), 64'(8'hA5));
    @(negedge clk);
    chk("t1_busy_cleared", 64'({f_busy, f_valid}), 64'(0));
    wait_idle("t1");

    // Weight wrap-around burst at full throughput.
    for (int i = 0; i < 6; i++) wr(1, 0, (60 + i) % WD, 8'(i + 1));
    wr_done();
    a0 = w_acc;
    start_bursts(0, 0, 0, 1, 60, 6);
    repeat (7) @(negedge clk);
    chk("t2_throughput", 64'(w_acc - a0), 64'(6));
    wait_idle("t2");

    // Scripted backpressure.
    fpat = '{1, 0, 0, 1, 1, 0, 1};
    f_mode = 2; a0 = f_acc;
    start_bursts(1, 12, 4, 0, 0, 0);
    wait_idle("t3");
    chk("t3_accept_count", 64'(f_acc - a0), 64'(4));
    f_mode = 0;

    // Read-before-write on the word being fetched.
    wr(0, 2, 10, 8'h11); wr_done();
    @(negedge clk);
    f_base = 10; f_len = 1; f_start = 1'b1; push_f(10, 1);
    @(negedge clk);
    f_start = 1'b0;
    wr_en = 1'b1; wr_sel = 1'b0; wr_bank = 3'd2; wr_addr = 6'd10; wr_data = 8'h55; fm[2][10] = 8'h55;
    @(negedge clk);
    wr_en = 1'b0;
    wait_idle("t4_old");
    start_bursts(1, 10, 1, 0, 0, 0);
    wait_idle("t4_new");

    // Ignored starts and out-of-range bank writes.
    @(negedge clk);
    f_base = 0; f_len = 0; f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    chk("t5_len0_ignored", 64'({f_busy, f_valid}), 64'(0));
    @(negedge clk);
    chk("t5_len0_still_idle", 64'({f_busy, f_valid}), 64'(0));
    f_mode = 1;
    start_bursts(1, 3, 6, 0, 0, 0);
    repeat (2) @(negedge clk);
    f_base = 20; f_len = 9; f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    wait_idle("t5_busy_start");
    f_mode = 0;
    wr(1, 7, 7, 8'hEE); wr(1, 5, 9, 8'hED); wr(0, 7, 4, 8'hEC); wr_done();
    start_bursts(1, 0, 32, 1, 0, 64);
    wait_idle("t5_bad_bank");

    // Asynchronous reset in the middle of a burst.
    a0 = f_acc;
    start_bursts(1, 8, 5, 0, 0, 0);
    for (t = 0; t < 50; t++) begin
      @(posedge clk);
      if (f_acc - a0 >= 2) break;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_ctrl", 64'({f_busy, f_valid, f_last}), 64'(0));
    chk("t6_async_data", 64'(f_data), 64'(0));
    fq.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t6_idle_after", 64'({f_busy, f_valid}), 64'(0));
    end
    start_bursts(1, 8, 5, 0, 0, 0);
    wait_idle("t6_reread");

    // Randomised traffic with concurrent bursts.
    f_mode = 1; w_mode = 1;
    for (int it = 0; it < 25; it++) begin
      for (int n = $urandom_range(0, 6); n > 0; n--)
        wr(1'($urandom), $urandom_range(0, 7), $urandom_range(0, 63), 8'($urandom));
      wr_done();
      start_bursts(1, $urandom_range(0, 31), $urandom_range(0, 40),
                   1, $urandom_range(0, 63), $urandom_range(0, 70));
      wait_idle("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/rs_glb_stream.md
Name: rs_glb_stream

Overview:
- Parametrised global buffer for the row-stationary PE array, holding N fmap banks and M weight banks with a shared write port.
- Each memory class has a burst read streamer that walks a base/length address range and delivers one word per cycle from all banks in parallel.
- Handshake is valid/ready, so the PE array can backpressure.
- Sits between the external loader/testbench and the PE-array row/column feeders.

Parameters:
DW, 8, data word width
FMAP_BANKS, 7, number of fmap banks (one per PE-array row feed)
FMAP_DEPTH, 32, words per fmap bank
WT_BANKS, 5, number of weight banks
WT_DEPTH, 64, words per weight bank
FA_W, $clog2(FMAP_DEPTH), fmap address width (derived)
WA_W, $clog2(WT_DEPTH), weight address width (derived)
BK_W, 3, bank-select width; must cover max(FMAP_BANKS, WT_BANKS)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe
wr_sel  in  1  0 = fmap memory, 1 = weight memory
wr_bank  in  BK_W  target bank
wr_addr  in  max(FA_W,WA_W)  target word address (upper bits ignored for fmap)
wr_data  in  DW  write data
f_start  in  1  start fmap burst (single-cycle pulse)
f_base  in  FA_W  first fmap address
f_len  in  FA_W+1  fmap burst length in words
f_busy  out  1  fmap burst in progress
f_valid  out  1  f_data valid
f_ready  in  1  consumer accepts f_data
f_last  out  1  marks final word of the burst
f_data  out  FMAP_BANKS*DW  bank k at bits [k*DW +: DW]
w_start, w_base (WA_W), w_len (WA_W+1), w_busy, w_valid, w_ready, w_last, w_data (WT_BANKS*DW): same roles for the weight memory

Behaviour:
- Reset (async assert, sync-to-clk deassert use):
  - streamers return to IDLE.
  - all busy/valid/last/data outputs are 0.
  - address and count registers are 0.
  - memory contents are not cleared.
- Write: when wr_en=1, write wr_data at the rising edge to the bank/address selected by wr_sel/wr_bank/wr_addr.
  - wr_bank >= bank count of the selected class: write dropped, no other effect.
  - wr_addr bits above the class address width are ignored.
- Streamer FSM, identical for each class (states IDLE, RUN):
  - IDLE: start=1 with len!=0 latches base into the address pointer and len into the remaining count, sets busy=1, goes to RUN.
  - IDLE: start with len=0 is ignored.
  - Start while busy is ignored.
  - fetch = RUN and remaining != 0 and (!valid or ready).
  - On fetch: every bank is read at the pointer into the data output register (1-cycle latency), valid=1 next cycle, pointer increments, remaining decrements.
  - Pointer wraps modulo DEPTH (base 30, len 4, depth 32 -> addresses 30, 31, 0, 1).
  - No fetch and valid and ready: valid drops to 0 next cycle.
  - valid and !ready: data, valid and last hold stable.
  - last=1 together with the word fetched when remaining was 1.
  - When the last word is accepted (valid and ready and last): return to IDLE and clear busy, last and valid on the same edge.
  - Throughput is 1 word/cycle when ready is held 1. First valid appears 1 cycle after entering RUN (2 cycles after start).
- Read/write collision, same bank and address in the same cycle: the stream returns the OLD data (read-before-write).
- The fmap and weight streamers are fully independent and may run concurrently with writes.
- Reset asserted mid-burst: burst aborted immediately, outputs 0, nothing resumes after reset.

Optional Feature:
- GLB_PRELOAD_EN defined:
  - string parameters FMAP_INIT and WT_INIT give $readmemb files, bank-major (bank k word a at line k*DEPTH+a), loaded at time 0.
  - Writes still override preloaded contents.
- Not defined: no file I/O, memories start uninitialised (X in simulation) until written.

Decomposition:
- Package rs_glb_pkg holds:
  - the default DW, bank and depth constants and BK_W;
  - the streamer state enum typedef (IDLE, RUN);
  - the wr_sel encodings (SEL_FMAP=0, SEL_WT=1).
- Sub-module rs_glb_streamer, parametrised on NBANK, DEPTH and DW, owns one memory class (bank arrays, write decode, FSM, output register). The top instantiates it twice and fans out the write port.

Test Plan:
- Write fmap bank 3 addr 5 = 8'hA5, stream f_base=5 f_len=1, f_ready=1 -> f_valid one cycle, f_data[31:24]=8'hA5, f_last=1, f_busy clears the same edge.
- Fill weight bank 0 addrs 60..63,0,1 with 1..6, stream w_base=60 w_len=6 -> words 1,2,3,4,5,6 on consecutive cycles, last on word 6 (wrap check).
- Fmap burst len 4 with f_ready toggled 1,0,0,1,1,0,1 -> each word held stable while ready=0, exactly 4 acceptances, no duplicates or drops.
- Same-cycle write of 8'h55 over 8'h11 at the address being fetched -> stream shows 8'h11; a second burst shows 8'h55.
- f_start with f_len=0, and f_start during a busy burst -> both ignored, busy/valid unchanged; wr_bank=7 with 5 weight banks -> no bank modified.
- rst_n pulsed low mid-burst (word 2 of 5) -> all outputs 0 asynchronously, FSM IDLE after release, memory contents intact on re-read.
